// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared drive-mode codes, FSM states and mode normalisation for stepper_seq
package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The reserved code 3 collapses to wave so the decoder only ever sees three modes.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    case (m)
      MODE_FULL: norm_mode = MODE_FULL;
      MODE_HALF: norm_mode = MODE_HALF;
      default:   norm_mode = MODE_WAVE;
    endcase
  endfunction

endpackage

// File: rtl/stepper_prescaler.sv
// rtl/stepper_prescaler.sv - step-rate divider; one tick every div clocks while run is high
module stepper_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d, div_eff;

  // A compare of >= lets a mid-move reduction of div take effect without waiting for a wrap.
  always_comb begin
    div_eff = (div == '0) ? DIV_W'(1) : div;
    tick    = run && (cnt_q >= div_eff - DIV_W'(1));
    cnt_d   = cnt_q;
    if (clear)     cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (run)  cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stepper_seq.sv
// rtl/stepper_seq.sv - N-phase stepper sequencer with wave/full/half modes and counted moves
module stepper_seq
  import stepper_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16,
  parameter int POS_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [CNT_W-1:0]  steps,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [POS_W-1:0]  pos,
  output logic [PHASES-1:0] coils
);

  localparam int IDX_N = 2 * PHASES;
  localparam int IW    = $clog2(IDX_N);
  localparam logic [IW:0]       IDX_NV = (IW+1)'(IDX_N);
  localparam logic [PHASES-1:0] ONE    = PHASES'(1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_step;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [PHASES-1:0] coils_q, coils_d;
  logic              busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic              accept, tick;
  logic [IW:0]       idx_ext, delta, idx_fwd, idx_rev;

  function automatic logic [PHASES-1:0] pattern(input logic [IW-1:0] i, input logic [1:0] m);
    int c, n;
    logic [PHASES-1:0] p;
    c = int'(i >> 1);
    n = (c + 1 == PHASES) ? 0 : c + 1;
    p = ONE << c;
    if (m == MODE_FULL || (m == MODE_HALF && i[0])) p = p | (ONE << n);
    return p;
  endfunction

  stepper_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (state_q == ST_RUN && enable),
    .clear (accept),
    .div   (div),
    .tick  (tick)
  );

  // Index moves by one in half-step and by two otherwise, wrapping in both directions.
  always_comb begin
    idx_ext  = {1'b0, idx_q};
    delta    = (mode_q == MODE_HALF) ? (IW+1)'(1) : (IW+1)'(2);
    idx_fwd  = idx_ext + delta;
    if (idx_fwd >= IDX_NV) idx_fwd = idx_fwd - IDX_NV;
    idx_rev  = (idx_ext >= delta) ? idx_ext - delta : idx_ext + IDX_NV - delta;
    idx_step = dir_q ? idx_fwd[IW-1:0] : idx_rev[IW-1:0];
  end

  always_comb begin
    accept    = (state_q == ST_IDLE) && start && !abort;
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dir_d  = dir;
          mode_d = norm_mode(mode);
          rem_d  = steps;
          if (steps == '0) done_d  = 1'b1;
          else             state_d = ST_RUN;
        end
      end
      default: begin
        if (abort) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (tick) begin
          idx_d = idx_step;
          pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
    busy_d  = (state_d == ST_RUN);
    coils_d = enable ? pattern(idx_d, mode_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mode_q    <= MODE_WAVE;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      pos_q     <= '0;
      coils_q   <= ONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      pos_q     <= pos_d;
      coils_q   <= coils_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign pos     = pos_q;
  assign coils   = coils_q;

endmodule
